// File: rtl/usb_rx_seq_checker.sv
// usb_rx_seq_checker: checks that an RX word stream increments by one (mod 2^DW),
// locks onto the sequence, counts accepted words and mismatches, and stretches
// each mismatch into an LED pulse.
// Optional macro SEQ_CHECK_STALL_EN: pseudo-random backpressure on in_ready via a
// 16-bit LFSR; when undefined, in_ready is held high after reset.
module usb_rx_seq_checker #(
  parameter int unsigned DW         = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LED_HOLD   = 50000000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_led,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned MATCH_W = 8;
  localparam int unsigned LED_W   = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LOCKING = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [DW-1:0]        exp_q, exp_n;
  logic [MATCH_W-1:0]   match_q, match_n;
  logic [LED_W-1:0]     led_q, led_n;
  logic [CNT_W-1:0]     byte_n, err_n;
  logic                 ready_n;
  logic                 beat;

`ifdef SEQ_CHECK_STALL_EN
  logic [15:0] lfsr_q, lfsr_n;
  logic        lfsr_fb;
`endif

  // Next-state, sequence check, counters and LED countdown
  always_comb begin
    state_n = state_q;
    exp_n   = exp_q;
    match_n = match_q;
    byte_n  = byte_cnt;
    err_n   = err_cnt;
    led_n   = (led_q != '0) ? led_q - LED_W'(1) : led_q;
    beat    = in_valid & in_ready;

    if (beat) begin
      byte_n = byte_cnt + CNT_W'(1);
      exp_n  = in_data + DW'(1);
      unique case (state_q)
        S_HUNT: begin
          match_n = '0;
          state_n = S_LOCKING;
        end
        S_LOCKING: begin
          if (in_data == exp_q) begin
            match_n = match_q + MATCH_W'(1);
            if (match_n == MATCH_W'(LOCK_COUNT)) state_n = S_LOCKED;
          end else begin
            match_n = '0;
          end
        end
        S_LOCKED: begin
          if (in_data != exp_q) begin
            if (err_cnt != '1) err_n = err_cnt + CNT_W'(1);
            led_n   = LED_W'(LED_HOLD);
            match_n = '0;
            state_n = S_LOCKING;
          end
        end
        default: state_n = S_HUNT;
      endcase
    end

    // clear overrides counters only; the sequence tracker keeps following the beat
    if (clear) begin
      byte_n = '0;
      err_n  = '0;
      led_n  = '0;
    end

`ifdef SEQ_CHECK_STALL_EN
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_n  = {lfsr_q[14:0], lfsr_fb};
    ready_n = (lfsr_n[1:0] != 2'b00);
`else
    ready_n = 1'b1;
`endif
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      exp_q    <= '0;
      match_q  <= '0;
      led_q    <= '0;
      byte_cnt <= '0;
      err_cnt  <= '0;
      in_ready <= 1'b0;
      locked   <= 1'b0;
      err_led  <= 1'b0;
`ifdef SEQ_CHECK_STALL_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      state_q  <= state_n;
      exp_q    <= exp_n;
      match_q  <= match_n;
      led_q    <= led_n;
      byte_cnt <= byte_n;
      err_cnt  <= err_n;
      in_ready <= ready_n;
      locked   <= (state_n == S_LOCKED);
      err_led  <= (led_n != '0);
`ifdef SEQ_CHECK_STALL_EN
      lfsr_q   <= lfsr_n;
`endif
    end
  end

endmodule
